// File: rtl/download_scheduler_if.sv
// Handshake bundle between the download scheduler and the camera/percent pairs.
// The master side drives the request and camera status; the slave side is the scheduler.
interface download_scheduler_if #(
  parameter int PCT_W = 4
);
  logic             dl_req;
  logic [PCT_W-1:0] cam1_pct;
  logic [PCT_W-1:0] cam2_pct;
  logic             cam1_film;
  logic             cam2_film;
  logic [1:0]       grant;
  logic [1:0]       drain_en;
  logic             busy;
  logic             done;
  logic             err_to;
  logic             last_srv;

  modport master (
    output dl_req, cam1_pct, cam2_pct, cam1_film, cam2_film,
    input  grant, drain_en, busy, done, err_to, last_srv
  );

  modport slave (
    input  dl_req, cam1_pct, cam2_pct, cam1_film, cam2_film,
    output grant, drain_en, busy, done, err_to, last_srv
  );
endinterface

// File: rtl/download_scheduler.sv
// Round-robin owner of the ground-link download channel for two cameras, draining
// one buffer at a time with a stall watchdog and a forced turnaround gap.
//
// state | meaning
// IDLE  | no owner; wait for dl_req with an eligible camera
// ARB   | one cycle; pick the owner, load grant/drain_en
// DRAIN | owner buffer being emptied; watch for done, abort or stall
// GAP   | channel turnaround, GAP_CYCLES cycles with no grant
module download_scheduler #(
  parameter int PCT_W      = 4,
  parameter int MAX_PCT    = 10,
  parameter int GAP_CYCLES = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  download_scheduler_if.slave   bus
);

  localparam int WD_W  = $clog2(TIMEOUT);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [PCT_W-1:0] MAX_CODE = PCT_W'(MAX_PCT);
  localparam logic [WD_W-1:0]  WD_TC    = WD_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_TC   = GAP_W'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARB   = 2'd1,
    S_DRAIN = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state;
  logic [1:0]       r_grant;
  logic             r_done;
  logic             r_err_to;
  logic             r_last_srv;
  logic             r_busy;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;
  logic [PCT_W-1:0] r_pct;

  state_t           w_nxt_state;
  logic [1:0]       w_nxt_grant;
  logic             w_nxt_done;
  logic             w_nxt_err_to;
  logic             w_nxt_last_srv;
  logic [WD_W-1:0]  w_nxt_wd;
  logic [GAP_W-1:0] w_nxt_gap;
  logic [PCT_W-1:0] w_nxt_pct;

  logic [PCT_W-1:0] w_pct1;
  logic [PCT_W-1:0] w_pct2;
  logic             w_elig1;
  logic             w_elig2;
  logic             w_own2;
  logic [PCT_W-1:0] w_own_pct;
  logic             w_own_film;

  // Codes above full scale read as full so a glitchy percent input cannot fake a change.
  assign w_pct1  = (bus.cam1_pct > MAX_CODE) ? MAX_CODE : bus.cam1_pct;
  assign w_pct2  = (bus.cam2_pct > MAX_CODE) ? MAX_CODE : bus.cam2_pct;
  assign w_elig1 = (w_pct1 != '0) && !bus.cam1_film;
  assign w_elig2 = (w_pct2 != '0) && !bus.cam2_film;

  assign w_own2     = r_grant[1];
  assign w_own_pct  = w_own2 ? w_pct2 : w_pct1;
  assign w_own_film = w_own2 ? bus.cam2_film : bus.cam1_film;

  always_comb begin
    w_nxt_state    = r_state;
    w_nxt_grant    = r_grant;
    w_nxt_done     = 1'b0;
    w_nxt_err_to   = r_err_to;
    w_nxt_last_srv = r_last_srv;
    w_nxt_wd       = r_wd;
    w_nxt_gap      = r_gap;
    w_nxt_pct      = r_pct;

    case (r_state)
      S_IDLE: begin
        w_nxt_grant = 2'b00;
        if (bus.dl_req && (w_elig1 || w_elig2)) begin
          w_nxt_state = S_ARB;
        end
      end

      S_ARB: begin
        w_nxt_wd = '0;
        if (w_elig1 && w_elig2) begin
          w_nxt_grant = r_last_srv ? 2'b01 : 2'b10;
          w_nxt_pct   = r_last_srv ? w_pct1 : w_pct2;
          w_nxt_state = S_DRAIN;
        end else if (w_elig1) begin
          w_nxt_grant = 2'b01;
          w_nxt_pct   = w_pct1;
          w_nxt_state = S_DRAIN;
        end else if (w_elig2) begin
          w_nxt_grant = 2'b10;
          w_nxt_pct   = w_pct2;
          w_nxt_state = S_DRAIN;
        end else begin
          w_nxt_grant = 2'b00;
          w_nxt_state = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (!bus.dl_req || w_own_film) begin
          w_nxt_grant = 2'b00;
          w_nxt_gap   = '0;
          w_nxt_state = S_GAP;
        end else if (w_own_pct == '0) begin
          w_nxt_done     = 1'b1;
          w_nxt_last_srv = w_own2;
          w_nxt_grant    = 2'b00;
          w_nxt_gap      = '0;
          w_nxt_state    = S_GAP;
        end else if (r_wd == WD_TC) begin
          w_nxt_err_to   = 1'b1;
          w_nxt_last_srv = w_own2;
          w_nxt_grant    = 2'b00;
          w_nxt_gap      = '0;
          w_nxt_state    = S_GAP;
        end else begin
          // Any movement of the fill level, up or down, counts as progress.
          w_nxt_pct = w_own_pct;
          if (w_own_pct != r_pct) begin
            w_nxt_wd = '0;
          end else if (r_wd != WD_TC) begin
            w_nxt_wd = r_wd + WD_W'(1);
          end
        end
      end

      S_GAP: begin
        w_nxt_grant = 2'b00;
        if (r_gap >= GAP_TC) begin
          w_nxt_state = S_IDLE;
        end else begin
          w_nxt_gap = r_gap + GAP_W'(1);
        end
      end

      default: begin
        w_nxt_grant = 2'b00;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_grant    <= 2'b00;
      r_done     <= 1'b0;
      r_err_to   <= 1'b0;
      r_last_srv <= 1'b0;
      r_busy     <= 1'b0;
      r_wd       <= '0;
      r_gap      <= '0;
      r_pct      <= '0;
    end else begin
      r_state    <= w_nxt_state;
      r_grant    <= w_nxt_grant;
      r_done     <= w_nxt_done;
      r_err_to   <= w_nxt_err_to;
      r_last_srv <= w_nxt_last_srv;
      r_busy     <= (w_nxt_state != S_IDLE);
      r_wd       <= w_nxt_wd;
      r_gap      <= w_nxt_gap;
      r_pct      <= w_nxt_pct;
    end
  end

  assign bus.grant    = r_grant;
  assign bus.drain_en = r_grant;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err_to   = r_err_to;
  assign bus.last_srv = r_last_srv;

endmodule

// File: tb/tb_download_scheduler.sv
// Directed bench for download_scheduler: hand-computed grant timing, round-robin,
// abort, watchdog and asynchronous reset behaviour.
module tb_download_scheduler;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  download_scheduler_if #(.PCT_W(4)) bus ();

  download_scheduler #(
    .PCT_W      (4),
    .MAX_PCT    (10),
    .GAP_CYCLES (4),
    .TIMEOUT    (64)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps until a grant appears (bounded), then checks owner and drain_en agreement.
  task automatic wait_grant(input string tag, input logic [1:0] exp, output int n);
    n = 0;
    while (bus.grant == 2'b00 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(bus.grant), 32'(exp));
    chk({tag, "_drain_en"}, 32'(bus.drain_en), 32'(exp));
  endtask

  // Camera-side model: the owner's buffer drops by one step per cycle down to 0.
  task automatic drain(input string tag, input bit c2, input int from);
    for (int p = from - 1; p >= 0; p--) begin
      if (c2) bus.cam2_pct = 4'(p);
      else    bus.cam1_pct = 4'(p);
      step();
      if (p == 1) chk({tag, "_hold"}, 32'(bus.grant), c2 ? 32'd2 : 32'd1);
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
    chk({tag, "_grant_off"}, 32'(bus.grant), 32'd0);
    chk({tag, "_last_srv"}, 32'(bus.last_srv), 32'(c2));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int  n;
    bit  seen;
    errors = 0;
    checks = 0;
    rst_n         = 1'b0;
    bus.dl_req    = 1'b0;
    bus.cam1_pct  = '0;
    bus.cam2_pct  = '0;
    bus.cam1_film = 1'b0;
    bus.cam2_film = 1'b0;
    #12;
    chk("rst_grant", 32'(bus.grant), 0);
    chk("rst_drain_en", 32'(bus.drain_en), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_err_to", 32'(bus.err_to), 0);
    chk("rst_last_srv", 32'(bus.last_srv), 0);
    rst_n = 1'b1;
    step();

    // Single eligible camera: ARB after first edge, grant after second.
    bus.cam1_pct  = 4'd9;
    bus.cam2_pct  = 4'd5;
    bus.cam2_film = 1'b1;
    bus.dl_req    = 1'b1;
    step();
    chk("t2_arb_busy", 32'(bus.busy), 1);
    chk("t2_arb_grant", 32'(bus.grant), 0);
    step();
    chk("t2_grant", 32'(bus.grant), 1);
    chk("t2_drain_en", 32'(bus.drain_en), 1);
    drain("t2", 1'b0, 9);
    step();
    chk("t2_done_pulse", 32'(bus.done), 0);
    step();
    step();
    chk("t2_gap_busy", 32'(bus.busy), 1);
    step();
    chk("t2_idle_busy", 32'(bus.busy), 0);
    chk("t2_idle_grant", 32'(bus.grant), 0);

    // cam2 alone so the round-robin pointer starts at cam2.
    bus.cam2_pct  = 4'd3;
    bus.cam2_film = 1'b0;
    wait_grant("pre3_grant", 2'b10, n);
    drain("pre3", 1'b1, 3);

    // Both eligible: 01, 10, 01, each GAP_CYCLES+2 cycles after the previous done.
    bus.cam1_pct = 4'd5;
    bus.cam2_pct = 4'd5;
    wait_grant("t3_g1", 2'b01, n);
    chk("t3_g1_delay", 32'(n), 6);
    drain("t3_d1", 1'b0, 5);
    bus.cam1_pct = 4'd5;
    wait_grant("t3_g2", 2'b10, n);
    chk("t3_g2_delay", 32'(n), 6);
    drain("t3_d2", 1'b1, 5);
    bus.cam2_pct = 4'd5;
    wait_grant("t3_g3", 2'b01, n);
    chk("t3_g3_delay", 32'(n), 6);
    drain("t3_d3", 1'b0, 5);

    // cam2 owner, dl_req drops: abort with no done and last_srv kept at cam1.
    bus.cam1_film = 1'b1;
    bus.cam2_pct  = 4'd7;
    wait_grant("t4_grant", 2'b10, n);
    bus.dl_req = 1'b0;
    step();
    chk("t4_grant_off", 32'(bus.grant), 0);
    chk("t4_no_done", 32'(bus.done), 0);
    chk("t4_last_srv", 32'(bus.last_srv), 0);
    repeat (6) step();
    chk("t4_idle", 32'(bus.busy), 0);

    // Frozen owner level trips the watchdog after 64 DRAIN cycles.
    bus.cam1_film = 1'b0;
    bus.cam1_pct  = 4'd4;
    bus.cam2_film = 1'b1;
    bus.dl_req    = 1'b1;
    wait_grant("t5_grant", 2'b01, n);
    repeat (63) step();
    chk("t5_pre_hold", 32'(bus.grant), 1);
    chk("t5_pre_err", 32'(bus.err_to), 0);
    step();
    chk("t5_err_to", 32'(bus.err_to), 1);
    chk("t5_grant_off", 32'(bus.grant), 0);
    chk("t5_no_done", 32'(bus.done), 0);
    bus.cam2_film = 1'b0;
    wait_grant("t5_next", 2'b10, n);
    chk("t5_err_sticky", 32'(bus.err_to), 1);
    bus.dl_req = 1'b0;
    repeat (7) step();

    // Owner starts filming: abort, and no re-grant while it films.
    bus.cam2_pct = 4'd0;
    bus.cam1_pct = 4'd6;
    bus.dl_req   = 1'b1;
    wait_grant("t6_grant", 2'b01, n);
    step();
    bus.cam1_film = 1'b1;
    step();
    chk("t6_abort", 32'(bus.grant), 0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.grant != 2'b00) seen = 1'b1;
    end
    chk("t6_no_regrant", 32'(seen), 0);
    chk("t6_idle", 32'(bus.busy), 0);

    // Over-range code is clamped and still granted; reset mid-drain clears everything.
    bus.cam1_film = 1'b0;
    bus.cam1_pct  = 4'd15;
    wait_grant("t1_clamp_grant", 2'b01, n);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_rst_grant", 32'(bus.grant), 0);
    chk("t1_rst_drain_en", 32'(bus.drain_en), 0);
    chk("t1_rst_busy", 32'(bus.busy), 0);
    chk("t1_rst_err_to", 32'(bus.err_to), 0);
    chk("t1_rst_last_srv", 32'(bus.last_srv), 0);
    #2 rst_n = 1'b1;
    #1;
    chk("t1_rel_busy", 32'(bus.busy), 0);
    step();
    chk("t1_rel_arb_busy", 32'(bus.busy), 1);
    chk("t1_rel_arb_grant", 32'(bus.grant), 0);
    step();
    chk("t1_rel_regrant", 32'(bus.grant), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
